issue_sched: RTL and testbench
==============================

// Module: issue_sched
// PURPOSE
//  Age-ordered issue queue and scheduler placed after the rename stage.
//  Buffers renamed instructions (physical tags plus ready bits) and watches the writeback/commit tag bus to wake up
//  waiting sources. Selects the oldest entry whose operands are all ready and presents it to one execute port
//  through a registered valid/ready output stage.
// PARAMETERS
//  DEPTH      8   queue entries (power of 2, >=2)
//  PREG_W     6   physical register tag width (64 pregs)
//  PAYLOAD_W  32  opaque per-instruction payload (opcode/imm/ROB id), passed through untouched
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, asynchronous, active-low
//  flush_i        in   1          branch mispredict: drop all queued and staged instructions
//  in_valid_i     in   1          renamed instruction offered
//  in_ready_o     out  1          queue can accept (count_o < DEPTH)
//  in_rs1_valid_i in   1          rs1 used
//  in_rs1_idx_i   in   PREG_W     rs1 physical tag
//  in_rs1_rdy_i   in   1          rs1 ready at rename
//  in_rs2_valid_i in   1          rs2 used
//  in_rs2_idx_i   in   PREG_W     rs2 physical tag
//  in_rs2_rdy_i   in   1          rs2 ready at rename
//  in_rd_valid_i  in   1          rd written
//  in_rd_idx_i    in   PREG_W     rd physical tag
//  in_payload_i   in   PAYLOAD_W  payload
//  wb_valid_i     in   1          wakeup broadcast valid
//  wb_idx_i       in   PREG_W     tag that became ready
//  iss_valid_o    out  1          staged instruction valid
//  iss_ready_i    in   1          execute port accepts
//  iss_rs1_idx_o  out  PREG_W     staged rs1 tag (0 if unused)
//  iss_rs2_idx_o  out  PREG_W     staged rs2 tag (0 if unused)
//  iss_rd_valid_o out  1          staged rd valid
//  iss_rd_idx_o   out  PREG_W     staged rd tag
//  iss_payload_o  out  PAYLOAD_W  staged payload
//  count_o        out  $clog2(DEPTH)+1  occupied queue entries (excludes staged output)
// BEHAVIOUR
//  Reset: all entries invalid, age matrix cleared, iss_valid_o=0, all iss_* data=0, count_o=0, in_ready_o=1.
//  Entry state: valid, rs1/rs2 {used,tag,rdy}, rd {valid,tag}, payload. An unused source, or source tag 0, is rdy=1.
//  Enqueue: happens when in_valid_i && in_ready_o && !flush_i. The instruction is written into the lowest-index
//   free entry. It is marked younger than every valid entry (DEPTHxDEPTH age matrix).
//  in_ready_o = (count_o < DEPTH). It ignores a same-cycle dequeue, so a full queue stalls 1 cycle after an issue.
//  Wakeup: wb_valid_i sets rdy on every valid entry source whose tag == wb_idx_i, visible next cycle.
//   If an enqueued source matches wb_idx_i in the same cycle, it is written rdy=1.
//   wb_idx_i==0 has no effect.
//  Select: candidates = valid entries with both sources rdy (registered state only; no same-cycle wakeup bypass).
//   The oldest candidate per the age matrix wins.
//  Stage load: load the winner into the output register and invalidate its entry when a candidate exists and
//   (!iss_valid_o || iss_ready_i). Otherwise the stage holds.
//  Output handshake: the transfer occurs on iss_valid_o && iss_ready_i.
//   Staged outputs are stable while iss_valid_o && !iss_ready_i.
//   iss_valid_o never drops without a transfer except on flush_i or reset.
//  Latency: an instruction enqueued at cycle N with both sources ready gives iss_valid_o=1 at N+1 (queue empty,
//   stage free). A source woken at cycle N is issue-eligible at N+1 and staged at N+2.
//  Throughput: 1 issue/cycle with iss_ready_i held high.
//  Simultaneous enqueue + stage load: both occur and count_o is unchanged.
//   A new entry may reuse a freed index only on the next cycle.
//  flush_i: next cycle all entries invalid, iss_valid_o=0, count_o=0. It overrides same-cycle enqueue, wakeup and
//   stage load. A handshake completing in the flush cycle still counts as transferred.
//  Asynchronous reset mid-operation: everything returns to reset values immediately. No partial entries survive.
//  Assertions: no enqueue when count_o==DEPTH; count_o == popcount(entry valid); age matrix antisymmetric over
//   valid entries.
// TESTING
//  T1 empty queue, enqueue rs1=p5 rdy, rs2 unused, rd=p40 at cycle 0 ->
//     iss_valid_o=1 at cycle 1, iss_rd_idx_o=40, count_o=0.
//  T2 enqueue A (rs1=p33 not rdy), then B (all rdy); wb p33 later ->
//     B issues first. A is staged exactly 2 cycles after the wb_valid_i cycle.
//  T3 fill 8 entries, none ready, iss_ready_i=1 ->
//     in_ready_o=0 and count_o=8; one wb frees an entry and in_ready_o=1 the cycle after dequeue.
//  T4 enqueue entries with tag p50 waiting in order X,Y,Z; single wb p50 -> issue order X,Y,Z on 3 consecutive cycles.
//  T5 enqueue rs2=p45 not rdy with wb_idx_i=45 in the same cycle -> treated ready, iss_valid_o=1 next cycle.
//  T6 iss_ready_i=0 with 3 queued entries, flush_i pulse ->
//     next cycle iss_valid_o=0 and count_o=0; a new enqueue then issues normally.

Source files
------------

// File: rtl/issue_sched.sv
// Age-ordered issue queue: sources wake from the writeback tag bus, and the oldest ready entry moves into a
// registered valid/ready output stage. A ready arrival into an empty queue goes straight to a free stage.
module issue_sched #(
   parameter int DEPTH     = 8,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic                    in_rs1_valid_i,
   input  logic [PREG_W-1:0]       in_rs1_idx_i,
   input  logic                    in_rs1_rdy_i,
   input  logic                    in_rs2_valid_i,
   input  logic [PREG_W-1:0]       in_rs2_idx_i,
   input  logic                    in_rs2_rdy_i,
   input  logic                    in_rd_valid_i,
   input  logic [PREG_W-1:0]       in_rd_idx_i,
   input  logic [PAYLOAD_W-1:0]    in_payload_i,
   input  logic                    wb_valid_i,
   input  logic [PREG_W-1:0]       wb_idx_i,
   output logic                    iss_valid_o,
   input  logic                    iss_ready_i,
   output logic [PREG_W-1:0]       iss_rs1_idx_o,
   output logic [PREG_W-1:0]       iss_rs2_idx_o,
   output logic                    iss_rd_valid_o,
   output logic [PREG_W-1:0]       iss_rd_idx_o,
   output logic [PAYLOAD_W-1:0]    iss_payload_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // Unused sources are stored as tag 0, which is permanently ready.
   typedef struct packed {
      logic [PREG_W-1:0]    rs1_tag;
      logic                 rs1_rdy;
      logic [PREG_W-1:0]    rs2_tag;
      logic                 rs2_rdy;
      logic                 rd_valid;
      logic [PREG_W-1:0]    rd_tag;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   entry_t [DEPTH-1:0]     ent_q;
   logic [DEPTH-1:0]       vld_q;
   logic [DEPTH*DEPTH-1:0] age_q;   // bit i*DEPTH+j set: entry i is older than entry j
   logic [CNT_W-1:0]       count_q;
   entry_t                 stg_q;
   logic                   stg_vld_q;

   entry_t           new_ent;
   logic             wb_hit, enq_req, enq, byp, load, stg_free, cand_any;
   logic [DEPTH-1:0] cand, beaten, win;
   logic [IDX_W-1:0] free_idx, win_idx;

   assign in_ready_o = (count_q < CNT_W'(DEPTH));
   assign wb_hit     = wb_valid_i && (wb_idx_i != '0);
   assign stg_free   = !stg_vld_q || iss_ready_i;

   always_comb begin
      new_ent          = '0;
      new_ent.rs1_tag  = in_rs1_valid_i ? in_rs1_idx_i : '0;
      new_ent.rs2_tag  = in_rs2_valid_i ? in_rs2_idx_i : '0;
      new_ent.rs1_rdy  = (new_ent.rs1_tag == '0) || in_rs1_rdy_i || (wb_hit && wb_idx_i == new_ent.rs1_tag);
      new_ent.rs2_rdy  = (new_ent.rs2_tag == '0) || in_rs2_rdy_i || (wb_hit && wb_idx_i == new_ent.rs2_tag);
      new_ent.rd_valid = in_rd_valid_i;
      new_ent.rd_tag   = in_rd_idx_i;
      new_ent.payload  = in_payload_i;
   end

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!vld_q[i]) free_idx = IDX_W'(i);
      end
   end

   // An entry wins when no other candidate is older than it.
   always_comb begin
      cand   = '0;
      beaten = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cand[i] = vld_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
      end
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (cand[j] && age_q[j*DEPTH + i]) beaten[i] = 1'b1;
         end
      end
      win     = cand & ~beaten;
      win_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (win[i]) win_idx = IDX_W'(i);
      end
   end

   assign cand_any = |cand;
   assign enq_req  = in_valid_i && in_ready_o && !flush_i;
   assign byp      = enq_req && (count_q == '0) && new_ent.rs1_rdy && new_ent.rs2_rdy && stg_free;
   assign enq      = enq_req && !byp;
   assign load     = cand_any && stg_free && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ent_q   <= '0;
         vld_q   <= '0;
         age_q   <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         vld_q   <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wb_hit && vld_q[i]) begin
               if (ent_q[i].rs1_tag == wb_idx_i) ent_q[i].rs1_rdy <= 1'b1;
               if (ent_q[i].rs2_tag == wb_idx_i) ent_q[i].rs2_rdy <= 1'b1;
            end
         end
         if (load) vld_q[win_idx] <= 1'b0;
         if (enq) begin
            ent_q[free_idx] <= new_ent;
            vld_q[free_idx] <= 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
               age_q[int'(free_idx)*DEPTH + j] <= 1'b0;
               age_q[j*DEPTH + int'(free_idx)] <= vld_q[j];
            end
         end
         count_q <= count_q + CNT_W'(enq) - CNT_W'(load);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stg_q     <= '0;
         stg_vld_q <= 1'b0;
      end else if (flush_i) begin
         stg_vld_q <= 1'b0;
      end else if (load) begin
         stg_q     <= ent_q[win_idx];
         stg_vld_q <= 1'b1;
      end else if (byp) begin
         stg_q     <= new_ent;
         stg_vld_q <= 1'b1;
      end else if (iss_ready_i) begin
         stg_vld_q <= 1'b0;
      end
   end

   assign iss_valid_o    = stg_vld_q;
   assign iss_rs1_idx_o  = stg_q.rs1_tag;
   assign iss_rs2_idx_o  = stg_q.rs2_tag;
   assign iss_rd_valid_o = stg_q.rd_valid;
   assign iss_rd_idx_o   = stg_q.rd_tag;
   assign iss_payload_o  = stg_q.payload;
   assign count_o        = count_q;

   logic [CNT_W-1:0] vld_pop;
   logic             age_ok;

   always_comb begin
      vld_pop = CNT_W'($countones(vld_q));
      age_ok  = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (i != j && vld_q[i] && vld_q[j] && (age_q[i*DEPTH + j] == age_q[j*DEPTH + i])) age_ok = 1'b0;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) enq |-> (count_q != CNT_W'(DEPTH)));
   a_count_pop:   assert property (@(posedge clk_i) disable iff (!rst_ni) count_q == vld_pop);
   a_age_anti:    assert property (@(posedge clk_i) disable iff (!rst_ni) age_ok);

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: directed vector table, hand sequences for multi-cycle cases, and random traffic
// compared every cycle against an age-ordered list model.
module tb_issue_sched;

   localparam int DEPTH     = 8;
   localparam int PREG_W    = 6;
   localparam int PAYLOAD_W = 32;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 flush_i = 1'b0;
   logic                 in_valid_i = 1'b0;
   logic                 in_ready_o;
   logic                 in_rs1_valid_i = 1'b0;
   logic [PREG_W-1:0]    in_rs1_idx_i = '0;
   logic                 in_rs1_rdy_i = 1'b0;
   logic                 in_rs2_valid_i = 1'b0;
   logic [PREG_W-1:0]    in_rs2_idx_i = '0;
   logic                 in_rs2_rdy_i = 1'b0;
   logic                 in_rd_valid_i = 1'b0;
   logic [PREG_W-1:0]    in_rd_idx_i = '0;
   logic [PAYLOAD_W-1:0] in_payload_i = '0;
   logic                 wb_valid_i = 1'b0;
   logic [PREG_W-1:0]    wb_idx_i = '0;
   logic                 iss_valid_o;
   logic                 iss_ready_i = 1'b0;
   logic [PREG_W-1:0]    iss_rs1_idx_o;
   logic [PREG_W-1:0]    iss_rs2_idx_o;
   logic                 iss_rd_valid_o;
   logic [PREG_W-1:0]    iss_rd_idx_o;
   logic [PAYLOAD_W-1:0] iss_payload_o;
   logic [CNT_W-1:0]     count_o;

   issue_sched #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_rs1_valid_i(in_rs1_valid_i), .in_rs1_idx_i(in_rs1_idx_i), .in_rs1_rdy_i(in_rs1_rdy_i),
      .in_rs2_valid_i(in_rs2_valid_i), .in_rs2_idx_i(in_rs2_idx_i), .in_rs2_rdy_i(in_rs2_rdy_i),
      .in_rd_valid_i(in_rd_valid_i), .in_rd_idx_i(in_rd_idx_i), .in_payload_i(in_payload_i),
      .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i),
      .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
      .iss_rs1_idx_o(iss_rs1_idx_o), .iss_rs2_idx_o(iss_rs2_idx_o),
      .iss_rd_valid_o(iss_rd_valid_o), .iss_rd_idx_o(iss_rd_idx_o),
      .iss_payload_o(iss_payload_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: list of waiting instructions, oldest first, plus the output stage.
   typedef struct {
      int r1; bit r1r; int r2; bit r2r; bit rdv; int rd; int pay;
   } m_ent_t;

   m_ent_t mq[$];
   m_ent_t mstg;
   bit     mstg_v;

   task automatic model_reset();
      mq.delete();
      mstg   = '{default: 0};
      mstg_v = 1'b0;
   endtask

   task automatic model_update();
      m_ent_t ne;
      int     sel;
      bit     free, wbh, byp, acc;
      wbh    = wb_valid_i && (wb_idx_i != 0);
      ne.r1  = in_rs1_valid_i ? int'(in_rs1_idx_i) : 0;
      ne.r2  = in_rs2_valid_i ? int'(in_rs2_idx_i) : 0;
      ne.r1r = (ne.r1 == 0) || in_rs1_rdy_i || (wbh && int'(wb_idx_i) == ne.r1);
      ne.r2r = (ne.r2 == 0) || in_rs2_rdy_i || (wbh && int'(wb_idx_i) == ne.r2);
      ne.rdv = in_rd_valid_i;
      ne.rd  = int'(in_rd_idx_i);
      ne.pay = int'(in_payload_i);
      if (flush_i) begin
         mq.delete();
         mstg_v = 1'b0;
         return;
      end
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].r1r && mq[i].r2r) sel = i;
      free = !mstg_v || iss_ready_i;
      acc  = in_valid_i && (mq.size() < DEPTH);
      byp  = acc && (mq.size() == 0) && ne.r1r && ne.r2r && free;
      if (wbh) foreach (mq[i]) begin
         if (mq[i].r1 == int'(wb_idx_i)) mq[i].r1r = 1'b1;
         if (mq[i].r2 == int'(wb_idx_i)) mq[i].r2r = 1'b1;
      end
      if (sel >= 0 && free) begin
         mstg   = mq[sel];
         mstg_v = 1'b1;
         mq.delete(sel);
      end else if (byp) begin
         mstg   = ne;
         mstg_v = 1'b1;
      end else if (iss_ready_i) begin
         mstg_v = 1'b0;
      end
      if (acc && !byp) mq.push_back(ne);
   endtask

   task automatic model_cmp();
      chk("m_iss_valid", int'(iss_valid_o), int'(mstg_v));
      chk("m_count", int'(count_o), mq.size());
      chk("m_in_ready", int'(in_ready_o), int'(mq.size() < DEPTH));
      if (mstg_v) begin
         chk("m_rs1", int'(iss_rs1_idx_o), mstg.r1);
         chk("m_rs2", int'(iss_rs2_idx_o), mstg.r2);
         chk("m_rd_valid", int'(iss_rd_valid_o), int'(mstg.rdv));
         chk("m_rd", int'(iss_rd_idx_o), mstg.rd);
         chk("m_payload", int'(iss_payload_o), mstg.pay);
      end
   endtask

   // Called at a negedge with inputs set; returns at the next negedge with outputs checked.
   task automatic step();
      model_update();
      @(posedge clk_i);
      @(negedge clk_i);
      model_cmp();
      in_valid_i = 1'b0;
      wb_valid_i = 1'b0;
      flush_i    = 1'b0;
   endtask

   task automatic put(input bit r1v, input int r1, input bit r1r, input bit r2v, input int r2, input bit r2r,
                      input int rd, input int pay);
      in_valid_i     = 1'b1;
      in_rs1_valid_i = r1v;
      in_rs1_idx_i   = PREG_W'(r1);
      in_rs1_rdy_i   = r1r;
      in_rs2_valid_i = r2v;
      in_rs2_idx_i   = PREG_W'(r2);
      in_rs2_rdy_i   = r2r;
      in_rd_valid_i  = 1'b1;
      in_rd_idx_i    = PREG_W'(rd);
      in_payload_i   = PAYLOAD_W'(pay);
   endtask

   task automatic wb(input int tag);
      wb_valid_i = 1'b1;
      wb_idx_i   = PREG_W'(tag);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_iss_valid"}, int'(iss_valid_o), 0);
      chk({tag, "_count"}, int'(count_o), 0);
      chk({tag, "_in_ready"}, int'(in_ready_o), 1);
      chk({tag, "_payload"}, int'(iss_payload_o), 0);
      chk({tag, "_rd"}, int'(iss_rd_idx_o), 0);
      chk({tag, "_rs1"}, int'(iss_rs1_idx_o), 0);
   endtask

   typedef struct {
      int in_v, r1v, r1, r1r, r2v, r2, r2r, rd, pay, wbv, wb, irdy;
      int e_v, e_rs1, e_rs2, e_rd, e_pay, e_cnt;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
      $fatal(1);
   end

   initial begin
      //          in_v r1v r1 r1r r2v r2 r2r rd  pay wbv wb irdy | e_v rs1 rs2 rd pay cnt
      tbl[0]  = '{1, 1, 5, 1, 0, 0, 0, 40, 1, 0, 0, 1,   1, 5, 0, 40, 1, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 33, 0, 0, 0, 0, 10, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1};
      tbl[3]  = '{1, 1, 3, 1, 1, 4, 1, 11, 3, 0, 0, 1,   0, 0, 0, 0, 0, 2};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    1, 3, 4, 11, 3, 1};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 1};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 33, 1,   0, 0, 0, 0, 0, 1};
      tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    1, 33, 0, 10, 2, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 0, 1, 45, 0, 20, 4, 1, 45, 1, 1, 0, 45, 20, 4, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 45, 20, 4, 0};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0};
      tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 12, 5, 0, 0, 0,   1, 0, 0, 12, 5, 0};
      tbl[13] = '{1, 1, 7, 1, 0, 0, 0, 13, 6, 0, 0, 0,   1, 0, 0, 12, 5, 1};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    1, 7, 0, 13, 6, 0};
      tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0};

      model_reset();
      #1;
      chk_reset_outputs("reset");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Directed table: T1, T2, T5 and stall/bypass interplay.
      for (int k = 0; k < 16; k++) begin
         in_valid_i     = (tbl[k].in_v != 0);
         in_rs1_valid_i = (tbl[k].r1v != 0);
         in_rs1_idx_i   = PREG_W'(tbl[k].r1);
         in_rs1_rdy_i   = (tbl[k].r1r != 0);
         in_rs2_valid_i = (tbl[k].r2v != 0);
         in_rs2_idx_i   = PREG_W'(tbl[k].r2);
         in_rs2_rdy_i   = (tbl[k].r2r != 0);
         in_rd_valid_i  = 1'b1;
         in_rd_idx_i    = PREG_W'(tbl[k].rd);
         in_payload_i   = PAYLOAD_W'(tbl[k].pay);
         wb_valid_i     = (tbl[k].wbv != 0);
         wb_idx_i       = PREG_W'(tbl[k].wb);
         iss_ready_i    = (tbl[k].irdy != 0);
         step();
         chk($sformatf("tbl%0d_iss_valid", k), int'(iss_valid_o), tbl[k].e_v);
         chk($sformatf("tbl%0d_count", k), int'(count_o), tbl[k].e_cnt);
         chk($sformatf("tbl%0d_in_ready", k), int'(in_ready_o), 1);
         if (tbl[k].e_v != 0) begin
            chk($sformatf("tbl%0d_rs1", k), int'(iss_rs1_idx_o), tbl[k].e_rs1);
            chk($sformatf("tbl%0d_rs2", k), int'(iss_rs2_idx_o), tbl[k].e_rs2);
            chk($sformatf("tbl%0d_rd", k), int'(iss_rd_idx_o), tbl[k].e_rd);
            chk($sformatf("tbl%0d_payload", k), int'(iss_payload_o), tbl[k].e_pay);
         end
      end

      // T3: fill with waiting entries, then one wakeup frees exactly one slot.
      iss_ready_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         put(1, 20 + i, 0, 0, 0, 0, i, 100 + i);
         step();
      end
      chk("t3_full_in_ready", int'(in_ready_o), 0);
      chk("t3_full_count", int'(count_o), DEPTH);
      put(1, 1, 1, 0, 0, 0, 9, 999);
      step();
      chk("t3_reject_count", int'(count_o), DEPTH);
      wb(23);
      step();
      chk("t3_woken_in_ready", int'(in_ready_o), 0);
      chk("t3_woken_iss_valid", int'(iss_valid_o), 0);
      step();
      chk("t3_issue_valid", int'(iss_valid_o), 1);
      chk("t3_issue_payload", int'(iss_payload_o), 103);
      chk("t3_after_count", int'(count_o), DEPTH - 1);
      chk("t3_after_in_ready", int'(in_ready_o), 1);
      flush_i = 1'b1;
      step();
      chk("t3_flush_count", int'(count_o), 0);

      // T4: one broadcast wakes three waiters; they issue in age order on consecutive cycles.
      for (int i = 0; i < 3; i++) begin
         put(1, 50, 0, 0, 0, 0, 30 + i, 200 + i);
         step();
      end
      wb(50);
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t4_order%0d_valid", i), int'(iss_valid_o), 1);
         chk($sformatf("t4_order%0d_payload", i), int'(iss_payload_o), 200 + i);
      end
      step();
      chk("t4_drained", int'(iss_valid_o), 0);

      // T6: flush with a stalled stage and queued entries.
      iss_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         put(0, 0, 0, 0, 0, 0, 40 + i, 250 + i);
         step();
      end
      chk("t6_pre_count", int'(count_o), 3);
      chk("t6_pre_valid", int'(iss_valid_o), 1);
      chk("t6_pre_payload", int'(iss_payload_o), 250);
      flush_i = 1'b1;
      step();
      chk("t6_flush_valid", int'(iss_valid_o), 0);
      chk("t6_flush_count", int'(count_o), 0);
      iss_ready_i = 1'b1;
      put(1, 9, 1, 0, 0, 0, 33, 300);
      step();
      chk("t6_new_valid", int'(iss_valid_o), 1);
      chk("t6_new_payload", int'(iss_payload_o), 300);
      step();

      // Asynchronous reset in the middle of activity.
      iss_ready_i = 1'b0;
      put(0, 0, 0, 0, 0, 0, 1, 400);
      step();
      put(1, 11, 0, 0, 0, 0, 2, 401);
      step();
      put(1, 12, 0, 0, 0, 0, 3, 402);
      step();
      #2 rst_ni = 1'b0;
      #1;
      chk_reset_outputs("arst");
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         in_valid_i     = ($urandom_range(0, 9) < 6);
         in_rs1_valid_i = ($urandom_range(0, 3) != 0);
         in_rs1_idx_i   = PREG_W'($urandom_range(0, 15));
         in_rs1_rdy_i   = ($urandom_range(0, 2) == 0);
         in_rs2_valid_i = ($urandom_range(0, 3) != 0);
         in_rs2_idx_i   = PREG_W'($urandom_range(0, 15));
         in_rs2_rdy_i   = ($urandom_range(0, 2) == 0);
         in_rd_valid_i  = ($urandom_range(0, 3) != 0);
         in_rd_idx_i    = PREG_W'($urandom_range(0, 63));
         in_payload_i   = PAYLOAD_W'($urandom);
         wb_valid_i     = ($urandom_range(0, 1) == 1);
         wb_idx_i       = PREG_W'($urandom_range(0, 15));
         iss_ready_i    = ($urandom_range(0, 9) < 7);
         flush_i        = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
